display_capture: RTL and testbench
==================================

DISPLAY_CAPTURE -- requirements
Module: display_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 16: consecutive identical synchronized samples required to accept a digit (2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: cycles without an accepted digit before a frame is declared stale (used only with CAPTURE_TIMEOUT_EN).
REQ-003 fastclk  input  1  100 MHz system clock; all logic on its rising edge.
REQ-004 resetin  input  1  asynchronous, active-low reset.
REQ-005 select  input  4  one-hot digit strobe from a scanning display driver; 4'b1000 = digit 3 (leftmost), 4'b0001 = digit 0.
REQ-006 hex_display  input  8  active-high segments, bit7..bit1 = a..g, bit0 = dp.
REQ-007 digits  output  16  captured hex value; nibble [15:12] = digit 3 ... [3:0] = digit 0.
REQ-008 dp  output  4  captured decimal points, bit i = digit i.
REQ-009 seg_err  output  4  bit i set when digit i's pattern in the last frame was not a legal hex glyph.
REQ-010 frame_valid  output  1  one-cycle pulse when digits/dp/seg_err update.
REQ-011 sel_err  output  1  one-cycle pulse when a non-one-hot, non-zero select is accepted.
REQ-012 stale  output  1  high while no digit has been accepted for TIMEOUT_CYCLES.

Function
REQ-013 select and hex_display SHALL pass through a 2-flop synchronizer before any use.
REQ-014 A stability counter SHALL clear on any change of the synchronized 12-bit {select, hex_display} and saturate at SETTLE_CYCLES-1.
REQ-015 A sample SHALL be accepted exactly once per hold, in the cycle the counter first reaches SETTLE_CYCLES-1.
REQ-016 Input-to-accept latency SHALL be 2 + SETTLE_CYCLES cycles for a held value.
REQ-017 Accepted select 4'b0000 SHALL be ignored with no other effect.
REQ-018 Accepted non-one-hot, non-zero select SHALL pulse sel_err for one cycle and leave the capture state unchanged.
REQ-019 Segments a..g SHALL decode as standard hex glyphs: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-020 Any other pattern SHALL decode to nibble 0 and set that digit's pending error bit.
REQ-021 A legal one-hot accept SHALL write the nibble, dp and error bit into digit i's shadow slot and set mask bit i; a repeat of digit i before frame completion overwrites the slot.
REQ-022 In the cycle after the accept that makes the mask 4'b1111, digits/dp/seg_err SHALL load from the shadow atomically, frame_valid SHALL pulse, and the mask SHALL clear.
REQ-023 Outputs SHALL hold between frames; a partial frame SHALL never reach the outputs.

Reset
REQ-024 On resetin low: digits=16'h0000, dp=4'h0, seg_err=4'h0, frame_valid=0, sel_err=0, stale=0; synchronizers, counters, shadow and mask cleared.
REQ-025 Reset mid-frame SHALL discard the partial frame; capture resumes from an empty mask after release.

Configuration
REQ-026 With CAPTURE_TIMEOUT_EN defined: an idle counter clears on every accept (including select 0000 and sel_err accepts); reaching TIMEOUT_CYCLES sets stale and clears the mask; stale clears on the next legal one-hot accept.
REQ-027 Without CAPTURE_TIMEOUT_EN: no idle counter is built, stale is tied 0, and a partial mask persists indefinitely.

Verification
REQ-028 Drive select 1000/0100/0010/0001 with 8'b11011010/11111100/01100000/11110110, 2 ms each -> one frame_valid, digits=16'h2019, dp=0, seg_err=0.
REQ-029 Toggle hex_display every 8 cycles with SETTLE_CYCLES=16 -> no accept, no frame_valid, outputs unchanged.
REQ-030 Digit 2 segments 8'b10101010 in an otherwise legal frame -> seg_err=4'b0100, nibble [11:8]=0.
REQ-031 Hold select 4'b0110 for 100 cycles -> exactly one sel_err pulse, mask unchanged.
REQ-032 Assert resetin after three digits, then feed a full frame 1,2,3,4 -> frame_valid only after all four new digits, digits=16'h1234.
REQ-033 With CAPTURE_TIMEOUT_EN and TIMEOUT_CYCLES=1000, stop strobing -> stale high after 1000 idle cycles; next legal digit clears it.

Source files
------------

// File: rtl/display_capture_if.sv
// Bus between a scanning seven-segment display tap and the capture block.
// The display side (select, hex_display) flows into the capture block and the
// captured frame plus status flags flow back out.
interface display_capture_if;
  logic [3:0]  select;
  logic [7:0]  hex_display;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  seg_err;
  logic        frame_valid;
  logic        sel_err;
  logic        stale;

  modport master (
    output select, hex_display,
    input  digits, dp, seg_err, frame_valid, sel_err, stale
  );

  modport slave (
    input  select, hex_display,
    output digits, dp, seg_err, frame_valid, sel_err, stale
  );
endinterface

// File: rtl/display_capture.sv
// display_capture: snoops a 4-digit multiplexed seven-segment display and
// rebuilds the hex value being shown. Raw strobes are synchronized, debounced
// by a stability counter, decoded, and collected in a shadow frame that is
// published to the outputs only once all four digits have been seen.
// Optional feature macro: CAPTURE_TIMEOUT_EN (idle timeout and stale flag).
module display_capture #(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             fastclk,
  input  logic             resetin,
  display_capture_if.slave bus
);

  localparam logic [7:0] LP_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LP_SETTLE_PRE  = 8'(SETTLE_CYCLES - 2);

  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_last;
  logic [7:0]  r_settle;

  logic        w_changed;
  logic        w_accept;
  logic [3:0]  w_sel;
  logic [6:0]  w_segs;
  logic        w_dpIn;
  logic [3:0]  w_nibble;
  logic        w_segBad;
  logic        w_oneHot;
  logic        w_selZero;
  logic        w_timeout;

  logic [15:0] r_shDigits;
  logic [3:0]  r_shDp;
  logic [3:0]  r_shErr;
  logic [3:0]  r_mask;
  logic [15:0] r_digits;
  logic [3:0]  r_dp;
  logic [3:0]  r_segErr;
  logic        r_frameValid;
  logic        r_selErr;

  assign w_sel     = r_sync2[11:8];
  assign w_segs    = r_sync2[7:1];
  assign w_dpIn    = r_sync2[0];
  assign w_oneHot  = $onehot(w_sel);
  assign w_selZero = (w_sel == 4'b0000);
  assign w_changed = (r_sync2 != r_last);
  // The counter is one short of saturation and the value is still steady, so
  // this edge is the first time it reaches SETTLE_CYCLES-1 for this hold.
  assign w_accept  = !w_changed && (r_settle == LP_SETTLE_PRE);

  // Two-flop synchronizer for the asynchronous display strobes, plus one more
  // stage used only to detect changes of the synchronized value.
  always_ff @(posedge fastclk or negedge resetin) begin
    if (!resetin) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_last  <= '0;
    end else begin
      r_sync1 <= {bus.select, bus.hex_display};
      r_sync2 <= r_sync1;
      r_last  <= r_sync2;
    end
  end

  // Stability counter: restarts on any change, saturates once settled.
  always_ff @(posedge fastclk or negedge resetin) begin
    if (!resetin) begin
      r_settle <= '0;
    end else if (w_changed) begin
      r_settle <= '0;
    end else if (r_settle != LP_SETTLE_LAST) begin
      r_settle <= r_settle + 8'd1;
    end
  end

  // Segment decoder: anything outside the sixteen hex glyphs becomes 0 with error.
  always_comb begin
    w_nibble = 4'h0;
    w_segBad = 1'b0;
    case (w_segs)
      7'b1111110: w_nibble = 4'h0;
      7'b0110000: w_nibble = 4'h1;
      7'b1101101: w_nibble = 4'h2;
      7'b1111001: w_nibble = 4'h3;
      7'b0110011: w_nibble = 4'h4;
      7'b1011011: w_nibble = 4'h5;
      7'b1011111: w_nibble = 4'h6;
      7'b1110000: w_nibble = 4'h7;
      7'b1111111: w_nibble = 4'h8;
      7'b1111011: w_nibble = 4'h9;
      7'b1110111: w_nibble = 4'hA;
      7'b0011111: w_nibble = 4'hB;
      7'b1001110: w_nibble = 4'hC;
      7'b0111101: w_nibble = 4'hD;
      7'b1001111: w_nibble = 4'hE;
      7'b1000111: w_nibble = 4'hF;
      default:    w_segBad = 1'b1;
    endcase
  end

`ifdef CAPTURE_TIMEOUT_EN
  localparam logic [31:0] LP_IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_idle;
  logic        r_stale;

  assign w_timeout = !w_accept && (r_idle == LP_IDLE_LAST);

  // Idle counter: any accept (even ignored or erroneous) proves the display is alive.
  always_ff @(posedge fastclk or negedge resetin) begin
    if (!resetin) begin
      r_idle <= '0;
    end else if (w_accept) begin
      r_idle <= '0;
    end else if (r_idle != LP_IDLE_LAST) begin
      r_idle <= r_idle + 32'd1;
    end
  end

  // Stale flag: raised on timeout, dropped only by a real digit.
  always_ff @(posedge fastclk or negedge resetin) begin
    if (!resetin) begin
      r_stale <= 1'b0;
    end else if (w_timeout) begin
      r_stale <= 1'b1;
    end else if (w_accept && w_oneHot) begin
      r_stale <= 1'b0;
    end
  end

  assign bus.stale = r_stale;
`else
  assign w_timeout = 1'b0;
  assign bus.stale = 1'b0;
`endif

  // Shadow frame collection and atomic publish once every digit slot is filled.
  always_ff @(posedge fastclk or negedge resetin) begin
    if (!resetin) begin
      r_shDigits   <= '0;
      r_shDp       <= '0;
      r_shErr      <= '0;
      r_mask       <= '0;
      r_digits     <= '0;
      r_dp         <= '0;
      r_segErr     <= '0;
      r_frameValid <= 1'b0;
      r_selErr     <= 1'b0;
    end else begin
      r_frameValid <= 1'b0;
      r_selErr     <= w_accept && !w_oneHot && !w_selZero;
      if (r_mask == 4'b1111) begin
        r_digits     <= r_shDigits;
        r_dp         <= r_shDp;
        r_segErr     <= r_shErr;
        r_frameValid <= 1'b1;
        r_mask       <= 4'b0000;
      end else if (w_accept && w_oneHot) begin
        r_mask <= r_mask | w_sel;
      end else if (w_timeout) begin
        r_mask <= 4'b0000;
      end
      for (int i = 0; i < 4; i++) begin
        if (w_accept && w_oneHot && w_sel[i]) begin
          r_shDigits[i*4 +: 4] <= w_nibble;
          r_shDp[i]            <= w_dpIn;
          r_shErr[i]           <= w_segBad;
        end
      end
    end
  end

  assign bus.digits      = r_digits;
  assign bus.dp          = r_dp;
  assign bus.seg_err     = r_segErr;
  assign bus.frame_valid = r_frameValid;
  assign bus.sel_err     = r_selErr;

endmodule

// File: tb/tb_display_capture.sv
// Directed bench for display_capture. Expected frames are queued as digits are
// driven and popped by a monitor whenever frame_valid pulses. Also exercises
// CAPTURE_TIMEOUT_EN when the macro is defined.
module tb_display_capture;
  localparam int S  = 16;
  localparam int TO = 1000;
  localparam int H  = 24;

  logic fastclk = 1'b0;
  logic resetin = 1'b0;

  display_capture_if bus();

  display_capture #(
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .fastclk(fastclk),
    .resetin(resetin),
    .bus    (bus)
  );

  always #5 fastclk = ~fastclk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  segErr;
  } frame_t;

  frame_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;
  int framesSeen  = 0;
  int selErrSeen  = 0;
  logic prevFv    = 1'b0;

  // Reference glyph table for building stimulus bytes.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [7:0] segByte(input logic [3:0] n, input logic dpBit);
    return {glyph(n), dpBit};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic [7:0] seg, input int hold);
    @(posedge fastclk);
    #1;
    bus.select      = sel;
    bus.hex_display = seg;
    repeat (hold) @(posedge fastclk);
  endtask

  task automatic pushFrame(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    frame_t f;
    f.digits = d;
    f.dp     = p;
    f.segErr = e;
    expQ.push_back(f);
  endtask

  // Monitor: scoreboard pop on every frame, sel_err pulse counting.
  always @(negedge fastclk) begin
    frame_t f;
    if (bus.sel_err === 1'b1) selErrSeen++;
    if (bus.frame_valid === 1'b1) begin
      framesSeen++;
      checkOutput("fv_single_cycle", {31'd0, prevFv}, 32'd0);
      checkOutput("frame_expected", {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) begin
        f = expQ.pop_front();
        checkOutput("frame_digits", {16'd0, bus.digits}, {16'd0, f.digits});
        checkOutput("frame_dp", {28'd0, bus.dp}, {28'd0, f.dp});
        checkOutput("frame_seg_err", {28'd0, bus.seg_err}, {28'd0, f.segErr});
      end
    end
    prevFv = bus.frame_valid;
  end

  initial begin
    int framesBefore;
    bus.select      = 4'b0000;
    bus.hex_display = 8'h00;

    // Reset state
    repeat (3) @(posedge fastclk);
    #1;
    checkOutput("reset_digits", {16'd0, bus.digits}, 32'd0);
    checkOutput("reset_dp", {28'd0, bus.dp}, 32'd0);
    checkOutput("reset_seg_err", {28'd0, bus.seg_err}, 32'd0);
    checkOutput("reset_frame_valid", {31'd0, bus.frame_valid}, 32'd0);
    checkOutput("reset_sel_err", {31'd0, bus.sel_err}, 32'd0);
    checkOutput("reset_stale", {31'd0, bus.stale}, 32'd0);
    @(negedge fastclk);
    resetin = 1'b1;
    repeat (H) @(posedge fastclk);

    // Basic frame 2019
    pushFrame(16'h2019, 4'h0, 4'h0);
    applyStimulus(4'b1000, 8'b11011010, H);
    applyStimulus(4'b0100, 8'b11111100, H);
    applyStimulus(4'b0010, 8'b01100000, H);
    applyStimulus(4'b0001, 8'b11110110, H);
    checkOutput("frames_2019", 32'(framesSeen), 32'd1);

    // Frame ABCD with decimal points, plus exact latency of the final digit
    pushFrame(16'hABCD, 4'b1001, 4'h0);
    applyStimulus(4'b1000, segByte(4'hA, 1'b1), H);
    applyStimulus(4'b0100, segByte(4'hB, 1'b0), H);
    applyStimulus(4'b0010, segByte(4'hC, 1'b0), H);
    checkOutput("hold_between_frames", {16'd0, bus.digits}, 32'h2019);
    @(posedge fastclk);
    #1;
    bus.select      = 4'b0001;
    bus.hex_display = segByte(4'hD, 1'b1);
    repeat (S + 2) @(posedge fastclk);
    #1;
    checkOutput("latency_not_early", {31'd0, bus.frame_valid}, 32'd0);
    @(posedge fastclk);
    #1;
    checkOutput("latency_on_time", {31'd0, bus.frame_valid}, 32'd1);
    repeat (H) @(posedge fastclk);
    checkOutput("frames_abcd", 32'(framesSeen), 32'd2);

    // Overwrite, ignored zero select, non-one-hot select mid-frame
    pushFrame(16'h7654, 4'h0, 4'h0);
    applyStimulus(4'b1000, segByte(4'h5, 1'b0), H);
    applyStimulus(4'b1000, segByte(4'h7, 1'b0), H);
    applyStimulus(4'b0000, segByte(4'h1, 1'b1), H);
    applyStimulus(4'b0100, segByte(4'h6, 1'b0), H);
    applyStimulus(4'b0110, segByte(4'h3, 1'b0), 100);
    checkOutput("sel_err_once", 32'(selErrSeen), 32'd1);
    checkOutput("no_frame_after_sel_err", 32'(framesSeen), 32'd2);
    applyStimulus(4'b0010, segByte(4'h5, 1'b0), H);
    applyStimulus(4'b0001, segByte(4'h4, 1'b0), H);
    checkOutput("frames_7654", 32'(framesSeen), 32'd3);

    // Illegal glyph on digit 2
    pushFrame(16'hE0F1, 4'h0, 4'b0100);
    applyStimulus(4'b1000, segByte(4'hE, 1'b0), H);
    applyStimulus(4'b0100, 8'b10101010, H);
    applyStimulus(4'b0010, segByte(4'hF, 1'b0), H);
    applyStimulus(4'b0001, segByte(4'h1, 1'b0), H);
    checkOutput("frames_e0f1", 32'(framesSeen), 32'd4);

    // Glitching digit 0 never settles; the partial frame must wait
    applyStimulus(4'b1000, segByte(4'h3, 1'b0), H);
    applyStimulus(4'b0100, segByte(4'h3, 1'b0), H);
    applyStimulus(4'b0010, segByte(4'h3, 1'b0), H);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(4'b0001, segByte((i % 2 == 0) ? 4'h8 : 4'h0, 1'b0), 8);
    end
    checkOutput("glitch_no_frame", 32'(framesSeen), 32'd4);
    checkOutput("glitch_outputs_held", {16'd0, bus.digits}, 32'hE0F1);
    pushFrame(16'h3339, 4'h0, 4'h0);
    applyStimulus(4'b0001, segByte(4'h9, 1'b0), H);
    checkOutput("frames_3339", 32'(framesSeen), 32'd5);

    // Reset in the middle of a frame
    applyStimulus(4'b1000, segByte(4'h9, 1'b0), H);
    applyStimulus(4'b0100, segByte(4'h9, 1'b0), H);
    applyStimulus(4'b0010, segByte(4'h9, 1'b0), H);
    @(negedge fastclk);
    resetin         = 1'b0;
    bus.select      = 4'b0000;
    bus.hex_display = 8'h00;
    repeat (2) @(posedge fastclk);
    #1;
    checkOutput("midreset_digits", {16'd0, bus.digits}, 32'd0);
    checkOutput("midreset_seg_err", {28'd0, bus.seg_err}, 32'd0);
    @(negedge fastclk);
    resetin = 1'b1;
    framesBefore = framesSeen;
    pushFrame(16'h1234, 4'h0, 4'h0);
    applyStimulus(4'b1000, segByte(4'h1, 1'b0), H);
    applyStimulus(4'b0100, segByte(4'h2, 1'b0), H);
    applyStimulus(4'b0010, segByte(4'h3, 1'b0), H);
    checkOutput("after_reset_partial", 32'(framesSeen), 32'(framesBefore));
    applyStimulus(4'b0001, segByte(4'h4, 1'b0), H);
    checkOutput("after_reset_full", 32'(framesSeen), 32'(framesBefore + 1));

    // Idle behaviour with a partial frame pending
    applyStimulus(4'b1000, segByte(4'hA, 1'b0), H);
    applyStimulus(4'b0100, segByte(4'hA, 1'b0), H);
    @(posedge fastclk);
    #1;
    bus.select      = 4'b0000;
    bus.hex_display = 8'h00;
`ifdef CAPTURE_TIMEOUT_EN
    repeat (S + 2 + TO - 10) @(posedge fastclk);
    #1;
    checkOutput("stale_not_early", {31'd0, bus.stale}, 32'd0);
    repeat (20) @(posedge fastclk);
    #1;
    checkOutput("stale_set", {31'd0, bus.stale}, 32'd1);
    applyStimulus(4'b0010, segByte(4'h5, 1'b0), H);
    checkOutput("stale_cleared", {31'd0, bus.stale}, 32'd0);
    applyStimulus(4'b0001, segByte(4'h6, 1'b0), H);
    checkOutput("mask_cleared_by_timeout", 32'(framesSeen), 32'(framesBefore + 1));
    pushFrame(16'hCD56, 4'h0, 4'h0);
    applyStimulus(4'b1000, segByte(4'hC, 1'b0), H);
    applyStimulus(4'b0100, segByte(4'hD, 1'b0), H);
`else
    repeat (S + 2 + TO + 200) @(posedge fastclk);
    #1;
    checkOutput("stale_tied_low", {31'd0, bus.stale}, 32'd0);
    pushFrame(16'hAA56, 4'h0, 4'h0);
    applyStimulus(4'b0010, segByte(4'h5, 1'b0), H);
    applyStimulus(4'b0001, segByte(4'h6, 1'b0), H);
`endif
    checkOutput("frames_final", 32'(framesSeen), 32'(framesBefore + 2));
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
